register_file_mp: RTL and testbench

Parametrised multi-port integer register file for the core's pipelined and dual-issue datapaths. It generalises the single-write, two-read file in width, depth and port count. It adds same-cycle write-to-read bypass and a per-register pending (scoreboard) bit that hazard logic queries on each read port. It sits between decode (reads, issue marking) and writeback (writes).

---
 rtl/common_types_pkg.sv | 10 +
 rtl/register_file_bypass.sv | 45 ++++
 rtl/register_file_mp.sv | 107 ++++++++++
 tb/tb_register_file_mp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Types shared across the core datapath: the default 32-bit word and the
// 5-bit architectural register select.
package common_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regsel_t;

  localparam regsel_t REG_ZERO = '0;

endpackage

// File: rtl/register_file_bypass.sv
// One read port of the register file: selects between the stored value and a
// same-cycle writeback, and reports whether the register still awaits a producer.
module register_file_bypass
  import common_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic [AW-1:0]        rsel,
  input  logic [WIDTH-1:0]     stored,
  input  logic                 pend,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AW-1:0]    wsel,
  input  logic [NWR*WIDTH-1:0] wdat,
  output logic [WIDTH-1:0]     rdat,
  output logic                 rpend
);

  logic             hit;
  logic [WIDTH-1:0] byp;

  // Later ports overwrite earlier matches, so the highest-index writer wins.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (wsel[j*AW +: AW] == rsel)) begin
        hit = 1'b1;
        byp = wdat[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rdat  = '0;
    rpend = 1'b0;
    if (rsel != '0) begin
      rdat  = hit ? byp : stored;
      rpend = pend & ~hit;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// pending scoreboard used by issue/hazard logic. Register 0 is hardwired to zero.
module register_file_mp
  import common_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NRD*AW-1:0]    rsel,
  output logic [NRD*WIDTH-1:0] rdat,
  output logic [NRD-1:0]       rpend,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AW-1:0]    wsel,
  input  logic [NWR*WIDTH-1:0] wdat,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_sel,
  input  logic                 flush,
  output logic [AW:0]          npend
);

  logic [WIDTH-1:0] mem [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [NREGS-1:0] whit;
  logic [WIDTH-1:0] wval [NREGS];
  logic [AW:0]      npend_nxt;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int r = 0; r < NREGS; r++) begin
      c = c + {{AW{1'b0}}, v[r]};
    end
    return c;
  endfunction

  // Per-register write decode; ascending port order gives the highest port priority.
  always_comb begin
    whit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wval[r] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (wsel[j*AW +: AW] != '0)) begin
        whit[wsel[j*AW +: AW]] = 1'b1;
        wval[wsel[j*AW +: AW]] = wdat[j*WIDTH +: WIDTH];
      end
    end
  end

  // Writeback clears, a fresh issue re-claims, flush wipes everything.
  always_comb begin
    pend_nxt = pend & ~whit;
    if (iss_en && (iss_sel != '0)) begin
      pend_nxt[iss_sel] = 1'b1;
    end
    if (flush) begin
      pend_nxt = '0;
    end
    pend_nxt[0] = 1'b0;
    npend_nxt   = popcount(pend_nxt);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
      pend  <= '0;
      npend <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (whit[r]) begin
          mem[r] <= wval[r];
        end
      end
      pend  <= pend_nxt;
      npend <= npend_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] s;
    assign s = rsel[i*AW +: AW];

    register_file_bypass #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .NWR   (NWR)
    ) u_byp (
      .rsel   (s),
      .stored (mem[s]),
      .pend   (pend[s]),
      .wen    (wen),
      .wsel   (wsel),
      .wdat   (wdat),
      .rdat   (rdat[i*WIDTH +: WIDTH]),
      .rpend  (rpend[i])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (NRD=2, NWR=2): directed scenarios
// pinned to literal values, then randomized traffic against a behavioural model.
module tb_register_file_mp;
  import common_types_pkg::*;

  logic        clk;
  logic        nrst;
  logic [9:0]  rsel;
  logic [63:0] rdat;
  logic [1:0]  rpend;
  logic [1:0]  wen;
  logic [9:0]  wsel;
  logic [63:0] wdat;
  logic        iss_en;
  logic [4:0]  iss_sel;
  logic        flush;
  logic [5:0]  npend;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  word_t       m_regs [32];
  logic [31:0] m_pend;

  register_file_mp #(
    .WIDTH (32),
    .NREGS (32),
    .NRD   (2),
    .NWR   (2)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .rsel    (rsel),
    .rdat    (rdat),
    .rpend   (rpend),
    .wen     (wen),
    .wsel    (wsel),
    .wdat    (wdat),
    .iss_en  (iss_en),
    .iss_sel (iss_sel),
    .flush   (flush),
    .npend   (npend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_written(input logic [4:0] s);
    for (int j = 0; j < 2; j++)
      if (wen[j] && wsel[j*5 +: 5] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic word_t m_rd(input logic [4:0] s);
    word_t v;
    if (s == 5'd0) return '0;
    v = m_regs[s];
    for (int j = 0; j < 2; j++)
      if (wen[j] && wsel[j*5 +: 5] == s) v = wdat[j*32 +: 32];
    return v;
  endfunction

  function automatic logic m_rp(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    return m_pend[s] && !m_written(s);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 1; r < 32; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_pend = '0;
  endtask

  task automatic m_clock();
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 2; j++) begin
      if (wen[j] && wsel[j*5 +: 5] != 5'd0) begin
        m_regs[wsel[j*5 +: 5]] = wdat[j*32 +: 32];
        w[wsel[j*5 +: 5]] = 1'b1;
      end
    end
    m_pend = m_pend & ~w;
    if (iss_en && iss_sel != 5'd0) m_pend[iss_sel] = 1'b1;
    if (flush) m_pend = '0;
    m_pend[0] = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rdat%0d", i), rdat[i*32 +: 32], m_rd(rsel[i*5 +: 5]));
        check($sformatf("rpend%0d", i), {31'd0, rpend[i]}, {31'd0, m_rp(rsel[i*5 +: 5])});
      end
      check("npend", {26'd0, npend}, 32'(m_count()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wen = '0; wsel = '0; wdat = '0; iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (nrst) m_clock();
    #1;
  endtask

  task automatic setw(input int j, input logic [4:0] s, input word_t d);
    wen[j] = 1'b1;
    wsel[j*5 +: 5] = s;
    wdat[j*32 +: 32] = d;
  endtask

  initial begin
    idle();
    rsel = '0;
    nrst = 1'b0;
    m_reset();
    chk_en = 1'b1;
    #2;
    for (int s = 0; s < 32; s++) begin
      rsel = {5'(31 - s), 5'(s)};
      #1;
      check("rst_rdat0", rdat[31:0], 32'h0);
      check("rst_rdat1", rdat[63:32], 32'h0);
      check("rst_rpend", {30'd0, rpend}, 32'h0);
    end
    check("rst_npend", {26'd0, npend}, 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Bypass of a fresh write, then stored value.
    setw(0, 5'd5, 32'hDEADBEEF); rsel = {5'd0, 5'd5}; #1;
    check("byp_x5", rdat[31:0], 32'hDEADBEEF);
    tick(); idle(); #1;
    check("store_x5", rdat[31:0], 32'hDEADBEEF);

    // Two ports hit x7: port 1 wins.
    setw(0, 5'd7, 32'h11); setw(1, 5'd7, 32'h22); rsel = {5'd7, 5'd5}; #1;
    check("dual_byp_x7", rdat[63:32], 32'h22);
    tick(); idle(); rsel = {5'd7, 5'd7}; #1;
    check("dual_st_x7_0", rdat[31:0], 32'h22);
    check("dual_st_x7_1", rdat[63:32], 32'h22);

    // Issue x3, then writeback.
    iss_en = 1'b1; iss_sel = 5'd3; tick(); idle(); rsel = {5'd0, 5'd3}; #1;
    check("iss_rpend_x3", {31'd0, rpend[0]}, 32'd1);
    check("iss_npend", {26'd0, npend}, 32'd1);
    setw(0, 5'd3, 32'h40); #1;
    check("wb_rpend_x3", {31'd0, rpend[0]}, 32'd0);
    check("wb_rdat_x3", rdat[31:0], 32'h40);
    tick(); idle(); #1;
    check("wb_npend", {26'd0, npend}, 32'd0);

    // Re-issue beats same-cycle write; then flush beats issue.
    iss_en = 1'b1; iss_sel = 5'd9; tick();
    setw(1, 5'd9, 32'h99); iss_en = 1'b1; iss_sel = 5'd9; tick(); idle();
    rsel = {5'd4, 5'd9}; #1;
    check("reiss_npend", {26'd0, npend}, 32'd1);
    check("reiss_rpend_x9", {31'd0, rpend[0]}, 32'd1);
    flush = 1'b1; iss_en = 1'b1; iss_sel = 5'd4; tick(); idle(); #1;
    check("flush_npend", {26'd0, npend}, 32'd0);
    check("flush_rpend", {30'd0, rpend}, 32'd0);

    // x0 ignores writes and issues.
    setw(1, 5'd0, 32'hFFFFFFFF); iss_en = 1'b1; iss_sel = 5'd0; rsel = {5'd0, 5'd0}; #1;
    check("x0_rdat", rdat[31:0], 32'h0);
    check("x0_rpend", {31'd0, rpend[0]}, 32'd0);
    tick(); idle(); #1;
    check("x0_npend", {26'd0, npend}, 32'd0);
    check("x0_rdat_next", rdat[63:32], 32'h0);

    // Asynchronous reset mid-cycle.
    setw(0, 5'd12, 32'hABCD); iss_en = 1'b1; iss_sel = 5'd3; tick(); idle();
    rsel = {5'd3, 5'd12}; #1;
    check("pre_rst_x12", rdat[31:0], 32'hABCD);
    check("pre_rst_npend", {26'd0, npend}, 32'd1);
    nrst = 1'b0; m_reset(); #1;
    check("async_rst_x12", rdat[31:0], 32'h0);
    check("async_rst_npend", {26'd0, npend}, 32'd0);
    check("async_rst_rpend", {30'd0, rpend}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Randomized traffic; selects biased to a small window to force collisions.
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 2; j++) begin
        wen[j] = 1'($urandom_range(0, 1));
        wsel[j*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wdat[j*32 +: 32] = $urandom;
        rsel[j*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      iss_en  = ($urandom_range(0, 2) != 0);
      iss_sel = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      flush   = ($urandom_range(0, 39) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
